// File: rtl/vec_arb_pkg.sv
// Shared types and helpers for the vector chunk arbiter: FSM state encoding
// and the chunk-count calculation used to size the per-vector counter.
package vec_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } vec_arb_state_t;

  localparam int unsigned StatsWidth = 16;

  // A partial final chunk still counts as a whole chunk.
  function automatic int chunks_per_vec(input int len, input int regs);
    return (len + regs - 1) / regs;
  endfunction

endpackage

// File: rtl/vec_chunk_arbiter_if.sv
// Requester/vector-unit/output-FIFO bundle for vec_chunk_arbiter; slave is the
// arbiter side. vec_count exists only when VEC_ARB_STATS_EN is defined.
interface vec_chunk_arbiter_if #(
  parameter int NumReq      = 2,
  parameter int WorkingRegs = 4,
  parameter int NBits       = 8
);
  import vec_arb_pkg::*;

  localparam int TagW = $clog2(NumReq);

  logic [NumReq-1:0]                                req_valid;
  logic [NumReq-1:0][WorkingRegs-1:0][NBits-1:0]    req_data;
  logic [NumReq-1:0]                                req_pop;
  logic [WorkingRegs-1:0][NBits-1:0]                op_in_data;
  logic [WorkingRegs-1:0][NBits-1:0]                op_out_data;
  logic                                             out_full;
  logic                                             out_push;
  logic [WorkingRegs-1:0][NBits-1:0]                out_data;
  logic [TagW-1:0]                                  out_tag;
  logic                                             out_last;
  logic [NumReq-1:0]                                grant;
  logic                                             busy;
`ifdef VEC_ARB_STATS_EN
  logic [NumReq-1:0][StatsWidth-1:0]                vec_count;
`endif

  modport slave (
`ifdef VEC_ARB_STATS_EN
    output vec_count,
`endif
    input  req_valid, req_data, op_out_data, out_full,
    output req_pop, op_in_data, out_push, out_data, out_tag, out_last,
    output grant, busy
  );

  modport master (
`ifdef VEC_ARB_STATS_EN
    input  vec_count,
`endif
    output req_valid, req_data, op_out_data, out_full,
    input  req_pop, op_in_data, out_push, out_data, out_tag, out_last,
    input  grant, busy
  );

endinterface

// File: rtl/vec_chunk_arbiter_rr_picker.sv
// Combinational round-robin select: first valid index at or after start_in,
// wrapping; found_out is low when nothing is valid.
module rr_picker #(
  parameter int NumReq = 2,
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] valid_in,
  input  logic [IdxW-1:0]   start_in,
  output logic [IdxW-1:0]   idx_out,
  output logic              found_out
);

  // Walk the candidates from farthest to nearest so the nearest valid one wins.
  always_comb begin
    int cand;
    cand      = 0;
    idx_out   = '0;
    found_out = 1'b0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      cand = (int'(start_in) + k) % NumReq;
      if (valid_in[cand]) begin
        idx_out   = IdxW'(cand);
        found_out = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vec_chunk_arbiter.sv
// Whole-vector round-robin arbiter feeding one shared chunked vector unit.
// Define VEC_ARB_STATS_EN to add per-requester completed-vector counters.
module vec_chunk_arbiter
  import vec_arb_pkg::*;
#(
  parameter int NumReq      = 2,
  parameter int InVecLength = 16,
  parameter int WorkingRegs = 4,
  parameter int NBits       = 8
) (
  input  logic                clk_in,
  input  logic                rst_in,
  vec_chunk_arbiter_if.slave  bus
);

  localparam int ChunksPerVec = chunks_per_vec(InVecLength, WorkingRegs);
  localparam int TagW         = $clog2(NumReq);
  localparam int CntW         = $clog2(ChunksPerVec) + 1;
  localparam logic [TagW-1:0] LastReq   = TagW'(NumReq - 1);
  localparam logic [CntW-1:0] LastChunk = CntW'(ChunksPerVec - 1);

  vec_arb_state_t  state_q, state_d;
  logic [TagW-1:0] owner_q, owner_d;
  logic [TagW-1:0] last_owner_q, last_owner_d;
  logic [CntW-1:0] chunk_idx_q, chunk_idx_d;

  logic [TagW-1:0] idle_start, hand_start;
  logic [TagW-1:0] idle_idx, hand_idx;
  logic            idle_found, hand_found;
  logic            xfer, is_last;

  function automatic logic [TagW-1:0] wrap_inc(input logic [TagW-1:0] i);
    return (i == LastReq) ? '0 : i + TagW'(1);
  endfunction

  assign idle_start = wrap_inc(last_owner_q);
  // Searching from owner+1 visits the owner last, so it only keeps the
  // grant when it is the sole valid requester.
  assign hand_start = wrap_inc(owner_q);

  rr_picker #(.NumReq(NumReq), .IdxW(TagW)) u_idle_pick (
    .valid_in  (bus.req_valid),
    .start_in  (idle_start),
    .idx_out   (idle_idx),
    .found_out (idle_found)
  );

  rr_picker #(.NumReq(NumReq), .IdxW(TagW)) u_hand_pick (
    .valid_in  (bus.req_valid),
    .start_in  (hand_start),
    .idx_out   (hand_idx),
    .found_out (hand_found)
  );

  assign xfer    = (state_q == STREAM) && bus.req_valid[owner_q] && !bus.out_full;
  assign is_last = (chunk_idx_q == LastChunk);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= LastReq;
      chunk_idx_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      chunk_idx_q  <= chunk_idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    chunk_idx_d  = chunk_idx_q;
    unique case (state_q)
      IDLE: begin
        if (idle_found) begin
          owner_d     = idle_idx;
          chunk_idx_d = '0;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (is_last) begin
            last_owner_d = owner_q;
            chunk_idx_d  = '0;
            if (hand_found) begin
              owner_d = hand_idx;
            end else begin
              state_d = IDLE;
            end
          end else begin
            chunk_idx_d = chunk_idx_q + CntW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Data is never touched here; the shared unit does all element arithmetic.
  always_comb begin
    bus.req_pop    = '0;
    bus.grant      = '0;
    bus.busy       = (state_q == STREAM);
    bus.out_push   = xfer;
    bus.out_last   = xfer && is_last;
    bus.out_tag    = '0;
    bus.op_in_data = '0;
    bus.out_data   = bus.op_out_data;
    if (xfer) begin
      bus.req_pop[owner_q] = 1'b1;
    end
    if (state_q == STREAM) begin
      bus.grant[owner_q] = 1'b1;
      bus.out_tag        = owner_q;
      bus.op_in_data     = bus.req_data[owner_q];
    end
  end

`ifdef VEC_ARB_STATS_EN
  logic [NumReq-1:0][StatsWidth-1:0] vec_count_q, vec_count_d;

  always_comb begin
    vec_count_d = vec_count_q;
    if (xfer && is_last) begin
      vec_count_d[owner_q] = vec_count_q[owner_q] + StatsWidth'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vec_count_q <= '0;
    end else begin
      vec_count_q <= vec_count_d;
    end
  end

  assign bus.vec_count = vec_count_q;
`endif

endmodule

// File: tb/tb_vec_chunk_arbiter.sv
// Directed bench for vec_chunk_arbiter: requester FIFOs are modelled by per-
// requester pop counters and the shared unit adds 1 to every lane.
module tb_vec_chunk_arbiter;
  import vec_arb_pkg::*;

  localparam int NumReq      = 2;
  localparam int InVecLength = 16;
  localparam int WorkingRegs = 4;
  localparam int NBits       = 8;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;

  always #5 clk_in = ~clk_in;

  vec_chunk_arbiter_if #(
    .NumReq(NumReq), .WorkingRegs(WorkingRegs), .NBits(NBits)
  ) bus ();

  vec_chunk_arbiter #(
    .NumReq(NumReq), .InVecLength(InVecLength),
    .WorkingRegs(WorkingRegs), .NBits(NBits)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int pop_cnt [NumReq];
  int vectors     = 0;
  int miscompares = 0;
  logic [NumReq-1:0] pops_seen;

  // Head of requester r's FIFO after pop_cnt[r] pops.
  always_comb begin
    for (int r = 0; r < NumReq; r++) begin
      for (int l = 0; l < WorkingRegs; l++) begin
        bus.req_data[r][l] = NBits'(r * 64 + pop_cnt[r] * 4 + l);
      end
    end
  end

  always_comb begin
    for (int l = 0; l < WorkingRegs; l++) begin
      bus.op_out_data[l] = bus.op_in_data[l] + NBits'(1);
    end
  end

  function automatic logic [WorkingRegs*NBits-1:0] expected_chunk(input int r, input int c);
    logic [WorkingRegs-1:0][NBits-1:0] v;
    for (int l = 0; l < WorkingRegs; l++) begin
      v[l] = NBits'(r * 64 + c * 4 + l + 1);
    end
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NumReq-1:0] v, input logic f);
    bus.req_valid = v;
    bus.out_full  = f;
    #1;
  endtask

  task automatic finishCycle();
    pops_seen = bus.req_pop;
    @(posedge clk_in);
    for (int r = 0; r < NumReq; r++) begin
      if (pops_seen[r]) pop_cnt[r]++;
    end
    @(negedge clk_in);
  endtask

  task automatic expectIdle(input logic [NumReq-1:0] v);
    applyStimulus(v, 1'b0);
    checkOutput("idle_pop",   64'(bus.req_pop),  64'd0);
    checkOutput("idle_push",  64'(bus.out_push), 64'd0);
    checkOutput("idle_grant", 64'(bus.grant),    64'd0);
    checkOutput("idle_busy",  64'(bus.busy),     64'd0);
    finishCycle();
  endtask

  task automatic expectXfer(input logic [NumReq-1:0] v, input int r, input int c,
                            input logic last);
    applyStimulus(v, 1'b0);
    checkOutput($sformatf("pop_r%0d_c%0d", r, c),   64'(bus.req_pop),  64'(1 << r));
    checkOutput($sformatf("push_r%0d_c%0d", r, c),  64'(bus.out_push), 64'd1);
    checkOutput($sformatf("tag_r%0d_c%0d", r, c),   64'(bus.out_tag),  64'(r));
    checkOutput($sformatf("last_r%0d_c%0d", r, c),  64'(bus.out_last), 64'(last));
    checkOutput($sformatf("grant_r%0d_c%0d", r, c), 64'(bus.grant),    64'(1 << r));
    checkOutput($sformatf("data_r%0d_c%0d", r, c),  64'(bus.out_data), 64'(expected_chunk(r, c)));
    finishCycle();
  endtask

  task automatic expectStall(input logic [NumReq-1:0] v, input logic f, input int r);
    applyStimulus(v, f);
    checkOutput("stall_pop",   64'(bus.req_pop),  64'd0);
    checkOutput("stall_push",  64'(bus.out_push), 64'd0);
    checkOutput("stall_grant", 64'(bus.grant),    64'(1 << r));
    checkOutput("stall_busy",  64'(bus.busy),     64'd1);
    finishCycle();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_grant"}, 64'(bus.grant),    64'd0);
    checkOutput({tag, "_pop"},   64'(bus.req_pop),  64'd0);
    checkOutput({tag, "_push"},  64'(bus.out_push), 64'd0);
    checkOutput({tag, "_busy"},  64'(bus.busy),     64'd0);
    checkOutput({tag, "_last"},  64'(bus.out_last), 64'd0);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.out_full  = 1'b0;
    for (int r = 0; r < NumReq; r++) pop_cnt[r] = 0;

    // Held reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      bus.req_valid = NumReq'($urandom);
      bus.out_full  = 1'($urandom);
      #1;
      checkResetOutputs("rst_hold");
    end
    @(negedge clk_in);
    rst_in = 1'b1;

    // Only requester 0: arbitration cycle, then two back-to-back vectors.
    $display("[TB] single requester");
    expectIdle(2'b01);
    for (int k = 0; k < 4; k++) expectXfer(2'b01, 0, k, k == 3);
    for (int k = 4; k < 7; k++) expectXfer(2'b01, 0, k, 1'b0);
    expectXfer(2'b11, 0, 7, 1'b1);

    // Both valid: ownership alternates with no gap.
    $display("[TB] alternating owners");
    for (int k = 0; k < 4; k++) expectXfer(2'b11, 1, k, k == 3);
    for (int k = 0; k < 4; k++) expectXfer(2'b11, 0, 8 + k, k == 3);
    for (int k = 0; k < 4; k++) expectXfer(2'b11, 1, 4 + k, k == 3);
    for (int k = 0; k < 4; k++) expectXfer(2'b11, 0, 12 + k, k == 3);

    // Output FIFO full for 3 cycles after chunk 1.
    $display("[TB] output backpressure");
    expectXfer(2'b11, 1, 8, 1'b0);
    expectXfer(2'b11, 1, 9, 1'b0);
    for (int i = 0; i < 3; i++) expectStall(2'b11, 1'b1, 1);
    expectXfer(2'b11, 1, 10, 1'b0);
    expectXfer(2'b11, 1, 11, 1'b1);

    // Owner's valid drops mid-vector while the other requester waits.
    $display("[TB] owner stall mid-vector");
    expectXfer(2'b11, 0, 16, 1'b0);
    expectXfer(2'b11, 0, 17, 1'b0);
    for (int i = 0; i < 2; i++) expectStall(2'b10, 1'b0, 0);
    expectXfer(2'b11, 0, 18, 1'b0);
    expectXfer(2'b11, 0, 19, 1'b1);
    expectXfer(2'b11, 1, 12, 1'b0);
    expectXfer(2'b11, 1, 13, 1'b0);

    // Asynchronous reset between edges, mid-vector.
    $display("[TB] async reset mid-vector");
    bus.req_valid = 2'b11;
    bus.out_full  = 1'b0;
    #2;
    rst_in = 1'b0;
    #1;
    checkResetOutputs("rst_async");
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    expectIdle(2'b11);
    for (int k = 0; k < 4; k++) expectXfer(2'b11, 0, 20 + k, k == 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vec_chunk_arbiter.md
# vec_chunk_arbiter

Shares one chunked elementwise vector unit (shift/scale style, `WorkingRegs` lanes per chunk) between `NumReq` requester chunk FIFOs. Ownership is granted for a whole vector of `ChunksPerVec` chunks, with round-robin between requesters. The block pops chunks from the owning requester, routes them through the shared combinational unit, and pushes the results with a source tag and a last-chunk flag into one output FIFO. It sits between the per-channel input FIFOs and the shared vector op in the mlops pipeline.

## Interface
Parameters:
- `NumReq`, 2, number of requesters (≥2)
- `InVecLength`, 16, elements per vector
- `WorkingRegs`, 4, lanes per chunk
- `NBits`, 8, bits per signed element

Ports:
- `clk_in`  in  1  single clock
- `rst_in`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NumReq  requester i has a chunk (its FIFO is not empty)
- `req_data`  in  NumReq×WorkingRegs×NBits signed  head chunk of each requester
- `req_pop`  out  NumReq  one-hot pop; combinational
- `op_in_data`  out  WorkingRegs×NBits signed  chunk sent to the shared unit
- `op_out_data`  in  WorkingRegs×NBits signed  result from the shared unit, same cycle
- `out_full`  in  1  output FIFO full
- `out_push`  out  1  push result; combinational
- `out_data`  out  WorkingRegs×NBits signed  equals `op_out_data`
- `out_tag`  out  $clog2(NumReq)  owner index
- `out_last`  out  1  last chunk of the vector
- `grant`  out  NumReq  one-hot owner; 0 in IDLE
- `busy`  out  1  state==STREAM

## Operation
- `ChunksPerVec = ceil(InVecLength/WorkingRegs)`. A partial final chunk passes all lanes; padding is handled upstream.
- States: IDLE, STREAM. Registers: `owner`, `last_owner`, `chunk_idx` ($clog2(ChunksPerVec)+1 bits).
- IDLE: if any `req_valid`, select the first valid index searching from `last_owner+1`, wrapping. Then set `owner` to it, `chunk_idx`←0, and go to STREAM. No pop in IDLE.
- STREAM: a transfer occurs when `req_valid[owner] && !out_full`.
  - On transfer: `req_pop[owner]`=1, `out_push`=1, `out_tag`=owner, `out_last`=(chunk_idx==ChunksPerVec-1), `chunk_idx`++.
- `op_in_data` = `req_data[owner]` whenever `busy`, otherwise 0.
- A non-last transfer, or no transfer, keeps the owner. Ownership never changes mid-vector, even if `req_valid[owner]` drops while others are valid.
- On the last transfer:
  - `last_owner`←owner and `chunk_idx`←0.
  - The next owner is chosen from the same-cycle `req_valid`, searching from owner+1 and excluding owner unless it is the only valid requester. Stay in STREAM with the new owner.
  - If none are valid, go to IDLE.
- Element arithmetic is entirely inside the shared unit. This block never modifies data.

## Timing
- Reset (async assert) forces: state IDLE, owner 0, `last_owner`=NumReq-1 (so requester 0 wins first), `chunk_idx` 0. All outputs are 0.
- Deassertion is synchronous to `clk_in` (external synchronizer).
- Reset mid-vector discards the partial vector. Chunks already pushed stay in the output FIFO. There is no recovery marker.
- Arbitration latency: valid seen in IDLE → first pop the next cycle.
- Back-to-back vectors between owners have zero bubble cycles.
- Throughput: 1 chunk per cycle when the owner is valid and `out_full`=0.
- `out_full` and `req_valid` are sampled in the same cycle as the pop/push. The downstream FIFO must accept a push in any cycle with `out_full`=0.

## Configuration
- `VEC_ARB_STATS_EN` defined: adds output `vec_count` (NumReq×16).
  - Per-requester count of completed vectors, incremented on the last transfer, wrapping at 2^16.
  - Reset to 0.
- Not defined: the port and its counters are absent. All other behaviour is identical.

## Structure
- Package `vec_arb_pkg`: state enum `vec_arb_state_t` {IDLE, STREAM} and function `chunks_per_vec(len, regs)`.
- Sub-module `rr_picker`: combinational round-robin select.
  - Inputs: valid vector and start index.
  - Outputs: index and found flag.
  - Instantiated once for IDLE and once for the last-transfer handoff.

## Test plan
Default parameters: NumReq=2, InVecLength=16, WorkingRegs=4.
- Reset: hold `rst_in`=0 with random inputs → `grant`, `req_pop`, `out_push`, `busy` all 0. Assert reset asynchronously between edges → outputs clear immediately.
- Only req0 valid continuously, with a unit returning input+1 → arbitration cycle, then 4 pushes in 4 cycles with tag 0, `out_last` on the 4th, data = input+1 per lane. Then an immediate new vector owned by 0 with no bubble.
- Both valid continuously → vector tags 0,1,0,1. Each vector is 4 consecutive pushes with no gap between vectors.
- `out_full`=1 for 3 cycles after chunk 1 → no pop or push in those cycles, `chunk_idx` held. Chunks 2–3 follow with no loss or duplication.
- req0 owns the vector and its valid drops after chunk 2 while req1 is valid → grant stays 0 and stalls. Chunks 2–3 come from req0 once it is valid again, then req1 gets the grant.
- Async reset after chunk 2 of req1's vector, then both valid → restart with requester 0, `chunk_idx` 0, and a full 4-chunk vector tagged 0.
